// File: rtl/user_gpio_pkg.sv
// ---------------------------------------------------------------------------
// user_gpio_pkg
// Shared definitions for the Wishbone GPIO controller:
//   - register offsets (byte address bits [7:0])
//   - Wishbone slave FSM state encoding
//   - byte-lane merge and write-one-to-clear helpers
// ---------------------------------------------------------------------------
package user_gpio_pkg;

  // Register offsets; each register is 64 bits wide, split into LO/HI words.
  localparam logic [7:0] OFF_OUT_LO   = 8'h00;
  localparam logic [7:0] OFF_OUT_HI   = 8'h04;
  localparam logic [7:0] OFF_OEB_LO   = 8'h08;
  localparam logic [7:0] OFF_OEB_HI   = 8'h0C;
  localparam logic [7:0] OFF_IN_LO    = 8'h10;
  localparam logic [7:0] OFF_IN_HI    = 8'h14;
  localparam logic [7:0] OFF_EN_LO    = 8'h18;
  localparam logic [7:0] OFF_EN_HI    = 8'h1C;
  localparam logic [7:0] OFF_STAT_LO  = 8'h20;
  localparam logic [7:0] OFF_STAT_HI  = 8'h24;
  localparam logic [7:0] OFF_EDGE_LO  = 8'h28;
  localparam logic [7:0] OFF_EDGE_HI  = 8'h2C;

  // Wishbone slave handshake states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } wb_state_e;

  // Expand the four byte selects into a 32-bit bit mask.
  function automatic logic [31:0] laneMask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Replace only the selected byte lanes of oldVal with newVal.
  function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  sel);
    logic [31:0] m;
    m = laneMask(sel);
    return (oldVal & ~m) | (newVal & m);
  endfunction

  // Bits to clear for a write-one-to-clear access, restricted to selected lanes.
  function automatic logic [31:0] w1cMask(input logic [31:0] wdata,
                                          input logic [3:0]  sel);
    return wdata & laneMask(sel);
  endfunction

endpackage

// File: rtl/user_wb_gpio_ctrl_edge_sync.sv
// ---------------------------------------------------------------------------
// gpio_edge_sync
// Brings asynchronous pad inputs into the clock domain and detects edges.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, clears every flop
//   async_i : raw pad inputs (WIDTH bits)
//   sync_o  : synchronised inputs (output of the last synchroniser stage)
//   rise_o  : synchronised value is 1 and was 0 one cycle earlier
//   fall_o  : synchronised value is 0 and was 1 one cycle earlier
// ---------------------------------------------------------------------------
module gpio_edge_sync
  import user_gpio_pkg::*;
#(
  parameter int WIDTH  = 38,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] hist_q;

  // Synchroniser chain followed by one history flop used for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
      hist_q <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      hist_q <= stage_q[STAGES-1];
    end
  end

  assign sync_o = stage_q[STAGES-1];
  assign rise_o = stage_q[STAGES-1] & ~hist_q;
  assign fall_o = ~stage_q[STAGES-1] & hist_q;

endmodule

// File: rtl/user_wb_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// user_wb_gpio_ctrl
// Wishbone-slave GPIO controller: register-controlled pad outputs and output
// enables, synchronised pad inputs and per-pin edge interrupts on user_irq.
// Ports:
//   wb_clk_i, wb_rst_i       : clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i     : Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]           : byte selects (writes only)
//   wbs_adr_i[31:0]          : byte address, block decodes [31:8]
//   wbs_dat_i[31:0]          : write data
//   wbs_ack_o                : one-cycle acknowledge
//   wbs_dat_o[31:0]          : read data, valid with ack, 0 otherwise
//   io_in/io_out/io_oeb      : pad input, output data, active-low enable
//   user_irq[IRQ_LINES-1:0]  : level interrupts, pin i drives line i%IRQ_LINES
// ---------------------------------------------------------------------------
module user_wb_gpio_ctrl
  import user_gpio_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter int          IRQ_LINES   = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_STATES = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [NUM_IO-1:0]    io_in,
  output logic [NUM_IO-1:0]    io_out,
  output logic [NUM_IO-1:0]    io_oeb,
  output logic [IRQ_LINES-1:0] user_irq
);

  // Implemented pins; every register is kept at 64 bits and ANDed with this
  // so bits above NUM_IO stay 0 and naturally read back as 0.
  localparam logic [63:0] PIN_MASK = (64'd1 << NUM_IO) - 64'd1;

  wb_state_e      state_q, state_d;
  logic [2:0]     waitCnt_q, waitCnt_d;
  logic [31:0]    rdDat_q, rdDat_d;
  logic [31:0]    rdMux;

  logic [63:0]    outData_q, outData_d;
  logic [63:0]    oeb_q, oeb_d;
  logic [63:0]    irqEn_q, irqEn_d;
  logic [63:0]    irqStat_q, irqStat_d;
  logic [63:0]    edgeSel_q, edgeSel_d;
  logic [63:0]    clrMask;
  logic [63:0]    edgeHit;
  logic [63:0]    irqActive;
  logic [IRQ_LINES-1:0] irq_q, irq_d;

  logic [NUM_IO-1:0] inSync, inRise, inFall;
  logic [63:0]    inExt, riseExt, fallExt;

  logic           busReq;
  logic           addrHit;
  logic           wrEn;
  logic [7:0]     offset;

  gpio_edge_sync #(
    .WIDTH  (NUM_IO),
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .async_i (io_in),
    .sync_o  (inSync),
    .rise_o  (inRise),
    .fall_o  (inFall)
  );

  assign inExt   = 64'(inSync);
  assign riseExt = 64'(inRise);
  assign fallExt = 64'(inFall);

  assign busReq  = wbs_cyc_i & wbs_stb_i;
  assign addrHit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign offset  = wbs_adr_i[7:0];
  // The master holds address/data until it sees ack, so the write commits on
  // the ACK cycle using the live bus values.
  assign wrEn    = (state_q == S_ACK) & busReq & wbs_we_i & addrHit;

  // Handshake FSM. Entry from IDLE needs stb high in IDLE itself, so a held
  // strobe only restarts a fresh access after returning to IDLE.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      S_IDLE: begin
        if (busReq && addrHit) begin
          waitCnt_d = '0;
          state_d   = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!busReq) begin
          state_d = S_IDLE;
        end else if (waitCnt_q == 3'(WAIT_STATES - 1)) begin
          state_d = S_ACK;
        end else begin
          waitCnt_d = waitCnt_q + 3'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read multiplexer; unmapped offsets return 0.
  always_comb begin
    rdMux = '0;
    case (offset)
      OFF_OUT_LO:  rdMux = outData_q[31:0];
      OFF_OUT_HI:  rdMux = outData_q[63:32];
      OFF_OEB_LO:  rdMux = oeb_q[31:0];
      OFF_OEB_HI:  rdMux = oeb_q[63:32];
      OFF_IN_LO:   rdMux = inExt[31:0];
      OFF_IN_HI:   rdMux = inExt[63:32];
      OFF_EN_LO:   rdMux = irqEn_q[31:0];
      OFF_EN_HI:   rdMux = irqEn_q[63:32];
      OFF_STAT_LO: rdMux = irqStat_q[31:0];
      OFF_STAT_HI: rdMux = irqStat_q[63:32];
      OFF_EDGE_LO: rdMux = edgeSel_q[31:0];
      OFF_EDGE_HI: rdMux = edgeSel_q[63:32];
      default:     rdMux = '0;
    endcase
  end

  // Read data is captured on the edge that enters ACK so it is valid for
  // exactly the cycle ack is high, and is zero at all other times.
  assign rdDat_d = (state_d == S_ACK) ? rdMux : '0;

  // Register writes with byte-lane merge; STAT takes a W1C clear mask.
  always_comb begin
    outData_d = outData_q;
    oeb_d     = oeb_q;
    irqEn_d   = irqEn_q;
    edgeSel_d = edgeSel_q;
    clrMask   = '0;
    if (wrEn) begin
      case (offset)
        OFF_OUT_LO:  outData_d[31:0]  = byteMerge(outData_q[31:0],  wbs_dat_i, wbs_sel_i);
        OFF_OUT_HI:  outData_d[63:32] = byteMerge(outData_q[63:32], wbs_dat_i, wbs_sel_i);
        OFF_OEB_LO:  oeb_d[31:0]      = byteMerge(oeb_q[31:0],      wbs_dat_i, wbs_sel_i);
        OFF_OEB_HI:  oeb_d[63:32]     = byteMerge(oeb_q[63:32],     wbs_dat_i, wbs_sel_i);
        OFF_EN_LO:   irqEn_d[31:0]    = byteMerge(irqEn_q[31:0],    wbs_dat_i, wbs_sel_i);
        OFF_EN_HI:   irqEn_d[63:32]   = byteMerge(irqEn_q[63:32],   wbs_dat_i, wbs_sel_i);
        OFF_EDGE_LO: edgeSel_d[31:0]  = byteMerge(edgeSel_q[31:0],  wbs_dat_i, wbs_sel_i);
        OFF_EDGE_HI: edgeSel_d[63:32] = byteMerge(edgeSel_q[63:32], wbs_dat_i, wbs_sel_i);
        OFF_STAT_LO: clrMask[31:0]    = w1cMask(wbs_dat_i, wbs_sel_i);
        OFF_STAT_HI: clrMask[63:32]   = w1cMask(wbs_dat_i, wbs_sel_i);
        default: ;
      endcase
    end
    outData_d = outData_d & PIN_MASK;
    oeb_d     = oeb_d     & PIN_MASK;
    irqEn_d   = irqEn_d   & PIN_MASK;
    edgeSel_d = edgeSel_d & PIN_MASK;
  end

  // Edge selected per pin by EDGE; the set term is ORed after the clear so a
  // simultaneous new edge wins over a W1C.
  assign edgeHit   = (riseExt & ~edgeSel_q) | (fallExt & edgeSel_q);
  assign irqStat_d = ((irqStat_q & ~clrMask) | edgeHit) & PIN_MASK;
  assign irqActive = irqStat_q & irqEn_q;

  // Interrupt line k collects every pin whose index is congruent to k.
  always_comb begin
    irq_d = '0;
    for (int k = 0; k < IRQ_LINES; k++) begin
      for (int i = 0; i < NUM_IO; i++) begin
        if ((i % IRQ_LINES) == k) begin
          irq_d[k] = irq_d[k] | irqActive[i];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      waitCnt_q <= '0;
      rdDat_q   <= '0;
      outData_q <= '0;
      oeb_q     <= PIN_MASK;
      irqEn_q   <= '0;
      irqStat_q <= '0;
      edgeSel_q <= '0;
      irq_q     <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      rdDat_q   <= rdDat_d;
      outData_q <= outData_d;
      oeb_q     <= oeb_d;
      irqEn_q   <= irqEn_d;
      irqStat_q <= irqStat_d;
      edgeSel_q <= edgeSel_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_ack_o = (state_q == S_ACK);
  assign wbs_dat_o = rdDat_q;
  assign io_out    = outData_q[NUM_IO-1:0];
  assign io_oeb    = oeb_q[NUM_IO-1:0];
  assign user_irq  = irq_q;

endmodule

// File: tb/tb_user_wb_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_user_wb_gpio_ctrl
// Self-checking bench for user_wb_gpio_ctrl with 38 pins, 3 IRQ lines,
// 3 wait states and a 2-stage synchroniser. Read expectations are queued
// when an access is issued and popped when the DUT acknowledges.
// ---------------------------------------------------------------------------
module tb_user_wb_gpio_ctrl;

  localparam int          NIO   = 38;
  localparam int          NIRQ  = 3;
  localparam int          WS    = 3;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [NIO-1:0] ALL1 = {NIO{1'b1}};

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cyc = 1'b0;
  logic            stb = 1'b0;
  logic            we  = 1'b0;
  logic [3:0]      sel = '0;
  logic [31:0]     adr = '0;
  logic [31:0]     datW = '0;
  logic            ack;
  logic [31:0]     datR;
  logic [NIO-1:0]  ioIn = '0;
  logic [NIO-1:0]  ioOut;
  logic [NIO-1:0]  ioOeb;
  logic [NIRQ-1:0] irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];

  user_wb_gpio_ctrl #(
    .NUM_IO      (NIO),
    .IRQ_LINES   (NIRQ),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (datW),
    .wbs_ack_o (ack),
    .wbs_dat_o (datR),
    .io_in     (ioIn),
    .io_out    (ioOut),
    .io_oeb    (ioOeb),
    .user_irq  (irq)
  );

  always #5 clk = ~clk;

  // One bounded Wishbone access; holds the bus through the ACK cycle.
  task automatic busXfer(input logic weIn, input logic [31:0] adrIn,
                         input logic [31:0] datIn, input logic [3:0] selIn,
                         output logic [31:0] rdata, output int lat,
                         output bit acked);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = weIn; adr = adrIn; datW = datIn; sel = selIn;
    lat = 0; acked = 1'b0; rdata = '0;
    while (!acked && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin
        acked = 1'b1;
        rdata = datR;
      end
    end
    if (acked) begin
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Reset values, then every offset read back.
  task automatic test_reset();
    logic [31:0] rd, exp;
    int lat;
    bit acked;
    rst = 1'b1;
    waitCycles(3);
    total++;
    if (ioOeb !== ALL1 || ioOut !== '0 || irq !== '0 || ack !== 1'b0 || datR !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: oeb=%h out=%h irq=%b ack=%b dat=%h, want oeb=%h rest 0",
               ioOeb, ioOut, irq, ack, datR, ALL1);
    end
    rst = 1'b0;
    waitCycles(2);
    for (int i = 0; i < 13; i++) begin
      exp = (i == 2) ? 32'hFFFF_FFFF : (i == 3) ? 32'h0000_003F : 32'h0;
      expQ.push_back(exp);
      busXfer(1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, rd, lat, acked);
      exp = expQ.pop_front();
      total++;
      if (!acked || rd !== exp) begin
        bad++;
        $display("[TB] FAIL reset_read_%02h: acked=%0b got=%h want=%h", i * 4, acked, rd, exp);
      end
    end
  endtask

  // Byte-lane write, ack latency and pulse width, bits above NUM_IO ignored.
  task automatic test_write();
    logic [31:0] rd, exp;
    int lat;
    bit acked;
    busXfer(1'b1, BASE + 32'h00, 32'hA5A5_A5A5, 4'b0011, rd, lat, acked);
    total++;
    if (!acked || lat != WS + 1) begin
      bad++;
      $display("[TB] FAIL write_latency: acked=%0b lat=%0d want %0d", acked, lat, WS + 1);
    end
    total++;
    if (ack !== 1'b0 || datR !== '0) begin
      bad++;
      $display("[TB] FAIL ack_pulse: ack=%b dat=%h after ack cycle, want 0/0", ack, datR);
    end
    busXfer(1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'b1111, rd, lat, acked);
    expQ.push_back(32'h0000_A5A5);
    busXfer(1'b0, BASE + 32'h00, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL out_lo_read: got=%h want=%h", rd, exp);
    end
    expQ.push_back(32'h0000_003F);
    busXfer(1'b0, BASE + 32'h04, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL out_hi_read: got=%h want=%h", rd, exp);
    end
    total++;
    if (ioOut !== 38'h3F_0000_A5A5) begin
      bad++;
      $display("[TB] FAIL io_out: got=%h want=%h", ioOut, 38'h3F_0000_A5A5);
    end
  endtask

  // Rising edge on pin 5 sets STAT 3 cycles later, user_irq[2] one after; W1C clears.
  task automatic test_irq_rise();
    logic [31:0] rd, exp;
    logic [NIRQ-1:0] expIrq;
    int lat;
    bit acked;
    busXfer(1'b1, BASE + 32'h18, 32'h0000_0020, 4'hF, rd, lat, acked);
    @(posedge clk); #1;
    ioIn[5] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      expIrq = (c == 4) ? 3'b100 : 3'b000;
      total++;
      if (irq !== expIrq) begin
        bad++;
        $display("[TB] FAIL irq_rise_c%0d: irq=%b want=%b", c, irq, expIrq);
      end
    end
    expQ.push_back(32'h0000_0020);
    busXfer(1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL stat_after_rise: got=%h want=%h", rd, exp);
    end
    expQ.push_back(32'h0000_0020);
    busXfer(1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL in_lo_read: got=%h want=%h", rd, exp);
    end
    busXfer(1'b1, BASE + 32'h20, 32'h0000_0020, 4'b0001, rd, lat, acked);
    @(posedge clk); #1;
    total++;
    if (irq !== 3'b000) begin
      bad++;
      $display("[TB] FAIL irq_after_w1c: irq=%b want=000", irq);
    end
    expQ.push_back(32'h0);
    busXfer(1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL stat_after_w1c: got=%h want=%h", rd, exp);
    end
  endtask

  // W1C commit and a fresh rising edge on the same edge: the set must win.
  task automatic test_w1c_race();
    logic [31:0] rd, exp;
    int lat;
    bit acked;
    ioIn[5] = 1'b0;
    waitCycles(5);
    expQ.push_back(32'h0);
    busXfer(1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL fall_ignored: got=%h want=%h", rd, exp);
    end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h20; datW = 32'h20; sel = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ioIn[5] = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) acked = 1'b1;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    total++;
    if (!acked) begin
      bad++;
      $display("[TB] FAIL race_ack: acked=0 want 1");
    end
    expQ.push_back(32'h0000_0020);
    busXfer(1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL set_wins: got=%h want=%h", rd, exp);
    end
    busXfer(1'b1, BASE + 32'h20, 32'h0000_0020, 4'b0001, rd, lat, acked);
    waitCycles(1);
  endtask

  // Falling-edge selection on pin 33 (HI word) routed to user_irq[0].
  task automatic test_edge_fall();
    logic [31:0] rd, exp;
    int lat;
    bit acked;
    busXfer(1'b1, BASE + 32'h1C, 32'h2, 4'hF, rd, lat, acked);
    busXfer(1'b1, BASE + 32'h2C, 32'h2, 4'hF, rd, lat, acked);
    ioIn[33] = 1'b1;
    waitCycles(5);
    total++;
    if (irq !== 3'b000) begin
      bad++;
      $display("[TB] FAIL rise_ignored_irq: irq=%b want=000", irq);
    end
    ioIn[33] = 1'b0;
    waitCycles(4);
    total++;
    if (irq !== 3'b001) begin
      bad++;
      $display("[TB] FAIL fall_irq: irq=%b want=001", irq);
    end
    expQ.push_back(32'h2);
    busXfer(1'b0, BASE + 32'h24, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL stat_hi: got=%h want=%h", rd, exp);
    end
    busXfer(1'b1, BASE + 32'h24, 32'h2, 4'b0001, rd, lat, acked);
    waitCycles(1);
    total++;
    if (irq !== 3'b000) begin
      bad++;
      $display("[TB] FAIL fall_irq_clear: irq=%b want=000", irq);
    end
  endtask

  // Strobe dropped in the 2nd wait cycle aborts; off-base address never acks.
  task automatic test_abort_and_miss();
    logic [31:0] rd, exp;
    int lat, ackSeen;
    bit acked;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; datW = 32'hFFFF_FFFF; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb = 1'b0;
    ackSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) ackSeen++;
    end
    cyc = 1'b0; we = 1'b0; sel = '0;
    total++;
    if (ackSeen != 0) begin
      bad++;
      $display("[TB] FAIL abort_ack: acks=%0d want 0", ackSeen);
    end
    busXfer(1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, rd, lat, acked);
    total++;
    if (acked) begin
      bad++;
      $display("[TB] FAIL miss_ack: acked=1 want 0");
    end
    expQ.push_back(32'h0000_A5A5);
    busXfer(1'b0, BASE, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL abort_no_write: got=%h want=%h", rd, exp);
    end
  endtask

  // Reset during the wait phase of a write: no ack, no commit, pads inputs.
  task automatic test_reset_mid();
    logic [31:0] rd, exp;
    int lat, ackSeen;
    bit acked;
    busXfer(1'b1, BASE + 32'h08, 32'h0000_FFFF, 4'hF, rd, lat, acked);
    total++;
    if (ioOeb !== 38'h3F_0000_FFFF) begin
      bad++;
      $display("[TB] FAIL oeb_write: got=%h want=%h", ioOeb, 38'h3F_0000_FFFF);
    end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h08; datW = 32'h0; sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    ackSeen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ack) ackSeen++;
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    rst = 1'b0;
    total++;
    if (ackSeen != 0 || ioOeb !== ALL1) begin
      bad++;
      $display("[TB] FAIL reset_mid: acks=%0d oeb=%h want 0 and %h", ackSeen, ioOeb, ALL1);
    end
    expQ.push_back(32'hFFFF_FFFF);
    busXfer(1'b0, BASE + 32'h08, 32'h0, 4'h0, rd, lat, acked);
    exp = expQ.pop_front();
    total++;
    if (!acked || rd !== exp) begin
      bad++;
      $display("[TB] FAIL oeb_after_reset: got=%h want=%h", rd, exp);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_irq_rise();
    test_w1c_race();
    test_edge_fall();
    test_abort_and_miss();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
